pc_vec_stage: RTL and testbench

PC_VEC_STAGE -- requirements
Module: pc_vec_stage

---
 rtl/pc_vec_stage.sv | 136 +++++++++++++
 tb/tb_pc_vec_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_vec_stage.sv
// Program-counter stage with edge-detected, vectorable external interrupts.
// Chooses the next fetch word address from start load, redirects and sequential increment.
module pc_vec_stage #(
  parameter int          NIRQ   = 4,
  parameter int          CW     = 4,
  parameter logic [29:0] RST_PC = 30'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_start,
  input  logic            cpu_stat_pc,
  input  logic [31:2]     cpu_start_adr,
  input  logic            csr_rmie,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [NIRQ-1:0] irq_en,
  input  logic            g_exception,
  input  logic            ecall_condition_ex,
  input  logic            jmp_condition_ex,
  input  logic            cmd_mret_ex,
  input  logic            cmd_sret_ex,
  input  logic [31:2]     jmp_adr_ex,
  input  logic [31:2]     csr_mtvec_ex,
  input  logic [31:2]     csr_mepc_ex,
  input  logic [31:2]     csr_sepc_ex,
  input  logic            tvec_mode,
  output logic [31:2]     pc,
  output logic [31:2]     pc_excep,
  output logic [NIRQ-1:0] irq_pending,
  output logic            irq_taken,
  output logic [CW-1:0]   irq_cause,
  output logic            interrupts_in_pc_state
);

  logic [29:0]     pc_q, pc_d;
  logic [29:0]     pc_ecall_q, pc_ecall_d;
  logic            adr_ld_q, adr_ld_d;
  logic [NIRQ-1:0] irq_d_q;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic            taken_q, taken_d;
  logic [CW-1:0]   cause_q, cause_d;

  logic [NIRQ-1:0] rise_s, active_s, clr_s;
  logic [CW-1:0]   sel_s;
  logic            irq_req_s, exc_req_s, irq_win_s;
  logic [29:0]     pc_inc_s, irq_tgt_s;

  assign rise_s    = irq_in & ~irq_d_q;
  assign active_s  = pend_q & irq_en;
  assign irq_req_s = (|active_s) & csr_rmie;
  assign exc_req_s = ecall_condition_ex | (g_exception & csr_rmie);
  assign pc_inc_s  = pc_q + 30'd1;
  // An interrupt only wins when nothing of higher priority claims this PC state.
  assign irq_win_s = cpu_stat_pc & ~adr_ld_q & irq_req_s & ~exc_req_s;
  assign irq_tgt_s = tvec_mode ? (csr_mtvec_ex + 30'(sel_s) + 30'd1) : csr_mtvec_ex;
  assign clr_s     = irq_win_s ? (NIRQ'(1'b1) << sel_s) : {NIRQ{1'b0}};

  // Lowest-index active channel; scanning downward lets the lowest overwrite last.
  always_comb begin
    sel_s = {CW{1'b0}};
    for (int i = NIRQ - 1; i >= 0; i--) begin
      sel_s = active_s[i] ? CW'(i) : sel_s;
    end
  end

  // Next-state selection for pc, latches and interrupt bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    adr_ld_d   = adr_ld_q;
    pc_ecall_d = pc_ecall_q;
    cause_d    = cause_q;
    if (cpu_stat_pc) begin
      adr_ld_d = 1'b0;
      if (adr_ld_q) begin
        pc_d = cpu_start_adr;
      end else if (exc_req_s) begin
        pc_d = csr_mtvec_ex;
      end else if (irq_req_s) begin
        pc_d = irq_tgt_s;
      end else if (cmd_mret_ex) begin
        pc_d = csr_mepc_ex;
      end else if (cmd_sret_ex) begin
        pc_d = csr_sepc_ex;
      end else if (jmp_condition_ex) begin
        pc_d = jmp_adr_ex;
      end else begin
        pc_d = pc_inc_s;
      end
      if (ecall_condition_ex) begin
        pc_ecall_d = pc_inc_s;
      end else begin
        pc_ecall_d = pc_ecall_q;
      end
    end else if (cpu_start) begin
      adr_ld_d = 1'b1;
    end else begin
      adr_ld_d = adr_ld_q;
    end
    if (irq_win_s) begin
      cause_d = sel_s;
    end else begin
      cause_d = cause_q;
    end
    pend_d  = (pend_q & ~clr_s) | rise_s;
    taken_d = irq_win_s;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RST_PC;
      pc_ecall_q <= 30'h0;
      adr_ld_q   <= 1'b0;
      irq_d_q    <= {NIRQ{1'b0}};
      pend_q     <= {NIRQ{1'b0}};
      taken_q    <= 1'b0;
      cause_q    <= {CW{1'b0}};
    end else begin
      pc_q       <= pc_d;
      pc_ecall_q <= pc_ecall_d;
      adr_ld_q   <= adr_ld_d;
      irq_d_q    <= irq_in;
      pend_q     <= pend_d;
      taken_q    <= taken_d;
      cause_q    <= cause_d;
    end
  end

  assign pc                     = pc_q;
  assign irq_pending            = pend_q;
  assign irq_taken              = taken_q;
  assign irq_cause              = cause_q;
  assign interrupts_in_pc_state = (|pend_q) & cpu_stat_pc;
  assign pc_excep = (ecall_condition_ex & ~irq_req_s) ? pc_ecall_q :
                    jmp_condition_ex ? jmp_adr_ex : pc_inc_s;

endmodule

// File: tb/tb_pc_vec_stage.sv
// Randomized and directed bench for pc_vec_stage against a behavioural model.
module tb_pc_vec_stage;
  localparam int NIRQ = 4;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cpu_start, cpu_stat_pc, csr_rmie, g_exception;
  logic            ecall_condition_ex, jmp_condition_ex, cmd_mret_ex, cmd_sret_ex, tvec_mode;
  logic [29:0]     cpu_start_adr, jmp_adr_ex, csr_mtvec_ex, csr_mepc_ex, csr_sepc_ex;
  logic [NIRQ-1:0] irq_in, irq_en;
  logic [29:0]     pc, pc_excep;
  logic [NIRQ-1:0] irq_pending;
  logic            irq_taken, interrupts_in_pc_state;
  logic [CW-1:0]   irq_cause;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [29:0]     m_pc, m_pc_ecall;
  bit              m_adr_ld, m_taken;
  bit [NIRQ-1:0]   m_prev, m_pend;
  int              m_cause;

  pc_vec_stage #(.NIRQ(NIRQ), .CW(CW), .RST_PC(30'h0)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_start(cpu_start), .cpu_stat_pc(cpu_stat_pc),
    .cpu_start_adr(cpu_start_adr), .csr_rmie(csr_rmie), .irq_in(irq_in), .irq_en(irq_en),
    .g_exception(g_exception), .ecall_condition_ex(ecall_condition_ex),
    .jmp_condition_ex(jmp_condition_ex), .cmd_mret_ex(cmd_mret_ex), .cmd_sret_ex(cmd_sret_ex),
    .jmp_adr_ex(jmp_adr_ex), .csr_mtvec_ex(csr_mtvec_ex), .csr_mepc_ex(csr_mepc_ex),
    .csr_sepc_ex(csr_sepc_ex), .tvec_mode(tvec_mode), .pc(pc), .pc_excep(pc_excep),
    .irq_pending(irq_pending), .irq_taken(irq_taken), .irq_cause(irq_cause),
    .interrupts_in_pc_state(interrupts_in_pc_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [NIRQ-1:0] v);
    for (int i = 0; i < NIRQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pc = 30'h0; m_pc_ecall = 30'h0; m_adr_ld = 0; m_taken = 0;
    m_prev = '0; m_pend = '0; m_cause = 0;
  endtask

  // Apply one clock of the rules to the model, using current inputs.
  task automatic model_step();
    bit [NIRQ-1:0] act, nxt_pend;
    bit irq_req, exc, win;
    int s;
    logic [29:0] nxt_pc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    act = m_pend & irq_en;
    s = lowest(act);
    irq_req = (s >= 0) && csr_rmie;
    exc = ecall_condition_ex || (g_exception && csr_rmie);
    win = cpu_stat_pc && !m_adr_ld && irq_req && !exc;
    nxt_pc = m_pc;
    if (cpu_stat_pc) begin
      if (m_adr_ld)              nxt_pc = cpu_start_adr;
      else if (exc)              nxt_pc = csr_mtvec_ex;
      else if (irq_req)          nxt_pc = tvec_mode ? 30'(csr_mtvec_ex + s + 1) : csr_mtvec_ex;
      else if (cmd_mret_ex)      nxt_pc = csr_mepc_ex;
      else if (cmd_sret_ex)      nxt_pc = csr_sepc_ex;
      else if (jmp_condition_ex) nxt_pc = jmp_adr_ex;
      else                       nxt_pc = 30'(m_pc + 1);
    end
    for (int i = 0; i < NIRQ; i++) begin
      if (irq_in[i] && !m_prev[i])  nxt_pend[i] = 1'b1;
      else if (win && i == s)       nxt_pend[i] = 1'b0;
      else                          nxt_pend[i] = m_pend[i];
    end
    if (ecall_condition_ex && cpu_stat_pc) m_pc_ecall = 30'(m_pc + 1);
    if (win) m_cause = s;
    m_adr_ld = cpu_stat_pc ? 1'b0 : (cpu_start ? 1'b1 : m_adr_ld);
    m_taken = win;
    m_pend = nxt_pend;
    m_prev = irq_in;
    m_pc = nxt_pc;
  endtask

  // Compare every DUT output against the model state and current inputs.
  task automatic compare();
    bit irq_req;
    logic [29:0] exp_excep;
    if (!rst_n) model_reset();
    irq_req = (lowest(m_pend & irq_en) >= 0) && csr_rmie;
    if (ecall_condition_ex && !irq_req) exp_excep = m_pc_ecall;
    else if (jmp_condition_ex)          exp_excep = jmp_adr_ex;
    else                                exp_excep = 30'(m_pc + 1);
    chk("pc", 32'(pc), 32'(m_pc));
    chk("pc_excep", 32'(pc_excep), 32'(exp_excep));
    chk("irq_pending", 32'(irq_pending), 32'(m_pend));
    chk("irq_taken", 32'(irq_taken), 32'(m_taken));
    chk("irq_cause", 32'(irq_cause), 32'(m_cause));
    chk("iips", 32'(interrupts_in_pc_state), 32'((|m_pend) && cpu_stat_pc));
  endtask

  task automatic tick();
    #1;
    compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_start = 0; cpu_stat_pc = 0; csr_rmie = 0; g_exception = 0;
    ecall_condition_ex = 0; jmp_condition_ex = 0; cmd_mret_ex = 0; cmd_sret_ex = 0;
    tvec_mode = 0; cpu_start_adr = '0; jmp_adr_ex = '0; csr_mtvec_ex = '0;
    csr_mepc_ex = '0; csr_sepc_ex = '0; irq_in = '0; irq_en = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    tick();
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_pending", 32'(irq_pending), 32'h0);
    rst_n = 1'b1;
    tick();

    // Start address load, then sequential step
    cpu_start_adr = 30'h100; cpu_start = 1; tick();
    cpu_start = 0; cpu_stat_pc = 1; tick();
    chk("start_pc", 32'(pc), 32'h100);
    tick();
    chk("start_inc", 32'(pc), 32'h101);

    // Vectored interrupts on channels 1 and 2 rising together
    tvec_mode = 1; csr_mtvec_ex = 30'h40; irq_en = 4'b1111; csr_rmie = 1; irq_in = 4'b0110;
    tick();
    tick();
    chk("vec_pc1", 32'(pc), 32'h42);
    chk("vec_cause1", 32'(irq_cause), 32'd1);
    chk("vec_pend1", 32'(irq_pending), 32'b0100);
    chk("vec_taken1", 32'(irq_taken), 32'd1);
    tick();
    chk("vec_pc2", 32'(pc), 32'h43);
    chk("vec_cause2", 32'(irq_cause), 32'd2);

    // Ecall beats a pending interrupt, which stays pending
    cpu_stat_pc = 0; irq_in = 4'b0111; tick();
    tvec_mode = 0; cpu_stat_pc = 1; ecall_condition_ex = 1; tick();
    chk("ecall_pc", 32'(pc), 32'h40);
    chk("ecall_pend0", 32'(irq_pending[0]), 32'd1);
    chk("ecall_no_taken", 32'(irq_taken), 32'd0);
    ecall_condition_ex = 0; tick();

    // Masked channel latches pending, stalls, then redirects
    irq_en = 4'b0111; cpu_stat_pc = 0; irq_in = 4'b1111; tick();
    chk("mask_pend", 32'(irq_pending), 32'b1000);
    cpu_stat_pc = 1; tick();
    chk("mask_noredir", 32'(pc), 32'h41);
    irq_en = 4'b1111; cpu_stat_pc = 0; tick();
    chk("stall_hold", 32'(pc), 32'h41);
    cpu_stat_pc = 1; tvec_mode = 1; tick();
    chk("unmask_pc", 32'(pc), 32'h44);
    chk("unmask_cause", 32'(irq_cause), 32'd3);

    // Wrap and mret over jmp
    irq_en = 4'b0000; cpu_start_adr = 30'h3FFFFFFF; cpu_start = 1; cpu_stat_pc = 0; tick();
    cpu_start = 0; cpu_stat_pc = 1; tick();
    chk("wrap_load", 32'(pc), 32'h3FFFFFFF);
    tick();
    chk("wrap_zero", 32'(pc), 32'h0);
    cmd_mret_ex = 1; jmp_condition_ex = 1; csr_mepc_ex = 30'h1234; jmp_adr_ex = 30'h555; tick();
    chk("mret_over_jmp", 32'(pc), 32'h1234);
    cmd_mret_ex = 0; jmp_condition_ex = 0;

    // Asynchronous reset with pending channels 1 and 3
    cpu_stat_pc = 0; irq_in = 4'b0000; tick();
    irq_in = 4'b1010; tick();
    chk("pre_rst_pend", 32'(irq_pending), 32'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pend", 32'(irq_pending), 32'h0);
    chk("async_pc", 32'(pc), 32'h0);
    chk("async_taken", 32'(irq_taken), 32'h0);
    model_reset();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    tick();

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      cpu_stat_pc        = ($urandom_range(0, 3) != 0);
      cpu_start          = ($urandom_range(0, 15) == 0);
      cpu_start_adr      = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFE : 30'($urandom());
      csr_rmie           = ($urandom_range(0, 3) != 0);
      irq_in             = irq_in ^ (($urandom_range(0, 2) == 0) ? NIRQ'($urandom()) : '0);
      irq_en             = ($urandom_range(0, 1) == 0) ? 4'b1111 : NIRQ'($urandom());
      g_exception        = ($urandom_range(0, 15) == 0);
      ecall_condition_ex = ($urandom_range(0, 15) == 0);
      jmp_condition_ex   = ($urandom_range(0, 3) == 0);
      cmd_mret_ex        = ($urandom_range(0, 15) == 0);
      cmd_sret_ex        = ($urandom_range(0, 15) == 0);
      tvec_mode          = $urandom_range(0, 1) == 1;
      jmp_adr_ex         = 30'($urandom());
      csr_mtvec_ex       = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFE : 30'($urandom());
      csr_mepc_ex        = 30'($urandom());
      csr_sepc_ex        = 30'($urandom());
      rst_n              = ($urandom_range(0, 199) != 0);
      tick();
      rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
